// File: rtl/cache_pkg.sv
// cache_pkg: shared cache/LSU types for the data cache and its backing DRAM model
package cache_pkg;

    typedef enum logic [1:0] {
        LW = 2'd0,
        SW = 2'd1
    } lsu_ops;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        XFER
    } dram_state_e;

    localparam logic [15:0] DRAM_FILL_TAG = 16'hDEAD;

endpackage

// File: rtl/dram_burst_model.sv
// dram_burst_model: behavioural DRAM with latency, strobed writes and wrapping read bursts
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready            : request handshake
//   req_op, req_addr               : LW (line burst) or SW (single word), byte address
//   req_wdata, req_wstrb           : write data and byte enables (SW only)
//   resp_valid/resp_ready          : response beat handshake
//   resp_data, resp_last           : beat data (zero for write acks), final-beat flag
module dram_burst_model
    import cache_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  lsu_ops              req_op,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_last
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = DATA_W / 8;
    localparam logic [IDX_W-1:0] LINE_MASK = IDX_W'(BURST_LEN - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    dram_state_e       state_q;
    logic              is_sw_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  beat_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     wstrb_q;
    logic [15:0]       cnt_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_last_q;
    logic [IDX_W-1:0]  rd_idx;
    logic              unused_addr;

    assign unused_addr = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

    // Critical word first: the offset advances with the beat but wraps inside the line.
    assign rd_idx     = (idx_q & ~LINE_MASK) | ((idx_q + beat_q) & LINE_MASK);
    assign resp_data  = (resp_valid_q && !is_sw_q) ? mem_q[rd_idx] : '0;
    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_last  = resp_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= DATA_W'({DRAM_FILL_TAG, 16'(i)});
            state_q      <= IDLE;
            is_sw_q      <= 1'b0;
            idx_q        <= '0;
            beat_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        is_sw_q     <= (req_op == SW);
                        idx_q       <= req_addr[IDX_W+1:2];
                        wdata_q     <= req_wdata;
                        wstrb_q     <= req_wstrb;
                        cnt_q       <= 16'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 16'd0) begin
                        state_q      <= XFER;
                        beat_q       <= '0;
                        resp_valid_q <= 1'b1;
                        resp_last_q  <= is_sw_q || (BURST_LEN == 1);
                        if (is_sw_q)
                            for (int b = 0; b < NB; b++)
                                if (wstrb_q[b])
                                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                XFER: begin
                    if (resp_ready) begin
                        if (resp_last_q) begin
                            state_q      <= IDLE;
                            resp_valid_q <= 1'b0;
                            resp_last_q  <= 1'b0;
                            req_ready_q  <= 1'b1;
                        end else begin
                            beat_q      <= beat_q + IDX_W'(1);
                            resp_last_q <= (beat_q + IDX_W'(1)) == LINE_MASK;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_burst_model.sv
// tb_dram_burst_model: directed scoreboard bench for the DRAM burst model
module tb_dram_burst_model;
    import cache_pkg::*;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    lsu_ops      req_op = LW;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_last;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [1024];
    beat_t sb [$];

    dram_burst_model #(.DATA_W(32), .DEPTH(1024), .LATENCY(4), .BURST_LEN(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_last(resp_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < 1024; i++) model[i] = {16'hDEAD, 16'(i)};
        sb.delete();
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
        int n = 0;
        logic [9:0] idx, w;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = lsu_ops'(op);
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        idx = addr[11:2];
        if (op == 2'd1) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
            sb.push_back('{d: 32'd0, l: 1'b1});
        end else begin
            for (int k = 0; k < 4; k++) begin
                w = (idx & 10'h3FC) | ((idx + 10'(k)) & 10'h003);
                sb.push_back('{d: model[w], l: (k == 3)});
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_drop", {31'b0, req_ready}, 32'd0);
    endtask

    task automatic recv(input int nbeats, input int stall_beat, input int stall_n);
        int got = 0;
        int guard = 0;
        int stalls = stall_n;
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            chk("latency_low", {31'b0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("latency_high", {31'b0, resp_valid}, 32'd1);
        while (got < nbeats && guard < 100) begin
            if (resp_valid) begin
                b = sb[0];
                chk($sformatf("beat%0d_data", got), resp_data, b.d);
                chk($sformatf("beat%0d_last", got), {31'b0, resp_last}, {31'b0, b.l});
                if (got == stall_beat && stalls > 0) begin
                    resp_ready = 1'b0;
                    stalls--;
                end else begin
                    resp_ready = 1'b1;
                    void'(sb.pop_front());
                    got++;
                end
            end
            @(negedge clk);
            guard++;
        end
        chk("beat_count", 32'(got), 32'(nbeats));
        chk("done_valid", {31'b0, resp_valid}, 32'd0);
        chk("done_ready", {31'b0, req_ready}, 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        model_init();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_last", {31'b0, resp_last}, 32'd0);

        send(2'd0, 32'h10, 32'h0, 4'h0);           recv(4, -1, 0);
        send(2'd0, 32'h1C, 32'h0, 4'h0);           recv(4, -1, 0);
        send(2'd1, 32'h14, 32'h12345678, 4'b0011); recv(1, -1, 0);
        send(2'd0, 32'h10, 32'h0, 4'h0);           recv(4, -1, 0);
        send(2'd0, 32'h20, 32'h0, 4'h0);           recv(4, 1, 3);
        send(2'd0, 32'h1010, 32'h0, 4'h0);         recv(4, -1, 0);
        send(2'd1, 32'h18, 32'hFFFFFFFF, 4'b0000); recv(1, -1, 0);
        send(2'd2, 32'h18, 32'h0, 4'h0);           recv(4, -1, 0);
        send(2'd1, 32'h3C, 32'hA5A5C3C3, 4'b1100); recv(1, -1, 0);
        send(2'd0, 32'h30, 32'h0, 4'h0);           recv(4, 2, 1);

        resp_ready = 1'b0;
        send(2'd1, 32'h08, 32'hCAFEBABE, 4'b1111);
        for (int i = 0; i < 10 && !resp_valid; i++) @(negedge clk);
        chk("xfer_before_rst", {31'b0, resp_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        model_init();
        chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        send(2'd0, 32'h0, 32'h0, 4'h0);            recv(4, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_burst_model.md
Name: dram_burst_model

Overview:
- Parametrised behavioural DRAM model that backs the data cache in simulation, driven directly by the cache controller.
- Adds valid/ready handshakes on request and response channels, a programmable access latency, byte-strobed single-word writes, and wrapping critical-word-first read bursts for cache line fills.
- Storage is reinitialised to a known pattern on reset, so sanity benches can predict read data.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8 and at least 32.
- DEPTH, 1024: number of words; power of two.
- LATENCY, 4: cycles from request acceptance to the first response beat; must be at least 1.
- BURST_LEN, 4: words per read burst (one cache line); power of two, at most DEPTH.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: model can accept a request.
- req_op, input, lsu_ops: LW (read burst) or SW (single write).
- req_addr, input, 32: byte address; bits [1:0] ignored.
- req_wdata, input, DATA_W: write data (SW only).
- req_wstrb, input, DATA_W/8: byte enables (SW only).
- resp_valid, output, 1: response beat present.
- resp_ready, input, 1: consumer accepts the beat.
- resp_data, output, DATA_W: read data; zero for write acks.
- resp_last, output, 1: final beat of the response.

Behaviour:
- Word index = req_addr[IDX_W+1:2], where IDX_W = log2(DEPTH). Upper address bits are ignored, so addresses alias modulo DEPTH.
- Reset (rst=1 at a clock edge):
  - Every word i is loaded with {16'hDEAD, i[15:0]}, zero-extended to DATA_W.
  - The FSM goes to IDLE.
  - req_ready=1; resp_valid=0; resp_data=0; resp_last=0; all counters are cleared.
  - Reset mid-operation abandons the transaction with no response, and any pending write is discarded.
- FSM states: IDLE, WAIT, XFER.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready: latch op, index, wdata and wstrb; load the latency counter with LATENCY-1; go to WAIT.
- WAIT:
  - req_ready=0; the counter decrements each cycle.
  - When the counter is 0, go to XFER. resp_valid rises exactly LATENCY cycles after the acceptance edge.
  - For SW, the write is performed on that same transition edge; only bytes with a set strobe are updated.
- XFER, read:
  - Beat k (0 <= k < BURST_LEN) returns the word at index {line_base, (off+k) mod BURST_LEN}, where off is the low log2(BURST_LEN) bits of the index. This wraps within the line, critical word first.
  - resp_last=1 on beat BURST_LEN-1 only.
  - Memory is read combinationally from the current beat pointer into resp_data.
- XFER, write: a single beat with resp_data=0 and resp_last=1.
- Backpressure:
  - While resp_valid && !resp_ready, resp_data and resp_last hold stable and the beat pointer does not advance.
  - A beat completes on resp_valid && resp_ready.
- Completion:
  - On completion of the resp_last beat, return to IDLE; req_ready=1 the next cycle.
  - There is no request overlap: one outstanding transaction at a time.
- An SW with all-zero strobes still completes and acknowledges, but leaves memory unchanged.
- An unknown or default op value is treated as LW.

Decomposition:
- cache_pkg: reuse lsu_ops (LW=0, SW=1). Add the dram_state_e enum {IDLE, WAIT, XFER} and the constant DRAM_FILL_TAG = 16'hDEAD.
- No sub-module: storage, FSM and counters fit in one module of about 200 lines.

Test Plan:
- Reset, then LW to req_addr=0x10 (index 4) with resp_ready=1 -> req_ready drops; resp_valid rises 4 cycles after acceptance; beats are 0xDEAD0004, 0xDEAD0005, 0xDEAD0006, 0xDEAD0007; resp_last is set on the 4th beat only.
- LW to req_addr=0x1C (index 7) -> burst wraps: 0xDEAD0007, 0xDEAD0004, 0xDEAD0005, 0xDEAD0006.
- SW to index 5 with wdata=0x12345678, wstrb=4'b0011, then LW to index 4 -> write ack has resp_data=0 and resp_last=1; the read's second beat is 0xDEAD5678.
- LW to index 8 with resp_ready held low for 3 cycles on beat 1 -> beat 1 data 0xDEAD0009 stays stable, with no skipped or duplicated beats and 4 beats total.
- req_addr=0x1010 (aliases to index 4) -> returns the same data as 0x10.
- Assert rst during XFER after an SW to index 2 -> resp_valid=0 and req_ready=1 the next cycle; a following LW to index 0 returns 0xDEAD0002 as its third beat.
